fetch_sequencer: RTL and testbench

Sequencer that owns the program counter and drives the synchronous program ROM on behalf of the front end. It issues ROM word addresses and absorbs the ROM's one-cycle read latency. It buffers fetched instructions in a 2-entry queue and presents them to decode through a valid/ready handshake. It also discards wrong-path fetches when a branch/jump redirect arrives. It sits between the program ROM and the decode stage.

---
 rtl/fetch_sequencer.sv | 127 ++++++++++++
 tb/tb_fetch_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Program-counter owner for the front end: issues ROM reads, absorbs the one-cycle
// ROM latency, and hands instructions to decode through a 2-entry valid/ready queue.
module fetch_sequencer #(
  parameter int unsigned         X_LENGTH   = 32,
  parameter int unsigned         ADDR_WIDTH = 5,
  parameter logic [X_LENGTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  redirect_valid,
  input  logic [X_LENGTH-1:0]   redirect_pc,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [X_LENGTH-1:0]   rom_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [X_LENGTH-1:0]   out_instruction,
  output logic [X_LENGTH-1:0]   out_pc
);

  localparam logic [X_LENGTH-1:0] PC_STEP    = X_LENGTH'(4);
  localparam logic [X_LENGTH-1:0] ALIGN_MASK = ~X_LENGTH'(3);
  localparam logic [X_LENGTH-1:0] RESET_BASE = RESET_PC & ALIGN_MASK;

  // Queue head lives directly in the out_* registers; tail is the second entry.
  logic [X_LENGTH-1:0] fetch_pc;
  logic                inflight;
  logic [X_LENGTH-1:0] inflight_pc;
  logic                tail_valid;
  logic [X_LENGTH-1:0] tail_instruction;
  logic [X_LENGTH-1:0] tail_pc;

  logic [X_LENGTH-1:0] redirect_base_c;
  logic [X_LENGTH-1:0] issue_pc_c;
  logic [1:0]          count_c;
  logic [2:0]          credit_c;
  logic                pop_c;
  logic                push_c;
  logic                issue_c;

  logic [X_LENGTH-1:0] fetch_pc_n;
  logic                head_valid_n;
  logic [X_LENGTH-1:0] head_instruction_n;
  logic [X_LENGTH-1:0] head_pc_n;
  logic                tail_valid_n;
  logic [X_LENGTH-1:0] tail_instruction_n;
  logic [X_LENGTH-1:0] tail_pc_n;

  assign redirect_base_c = redirect_pc & ALIGN_MASK;
  assign issue_pc_c      = redirect_valid ? redirect_base_c : fetch_pc;
  assign rom_address     = rst_n ? issue_pc_c[ADDR_WIDTH+1:2] : RESET_BASE[ADDR_WIDTH+1:2];

  // Credit check: a read issued now must find a free slot when it returns.
  assign pop_c    = out_valid && out_ready;
  assign count_c  = 2'(out_valid) + 2'(tail_valid);
  assign credit_c = 3'(count_c) + 3'(inflight) - 3'(pop_c);
  assign issue_c  = enable && (redirect_valid || (credit_c < 3'd2));
  assign push_c   = inflight && !redirect_valid;

  always_comb begin
    fetch_pc_n         = fetch_pc;
    head_valid_n       = out_valid;
    head_instruction_n = out_instruction;
    head_pc_n          = out_pc;
    tail_valid_n       = tail_valid;
    tail_instruction_n = tail_instruction;
    tail_pc_n          = tail_pc;

    if (issue_c) begin
      fetch_pc_n = issue_pc_c + PC_STEP;
    end else if (redirect_valid) begin
      fetch_pc_n = redirect_base_c;
    end

    if (redirect_valid) begin
      head_valid_n = 1'b0;
      tail_valid_n = 1'b0;
    end else begin
      if (pop_c) begin
        head_valid_n = tail_valid;
        if (tail_valid) begin
          head_instruction_n = tail_instruction;
          head_pc_n          = tail_pc;
        end
        tail_valid_n = 1'b0;
      end
      if (push_c) begin
        if (!head_valid_n) begin
          head_valid_n       = 1'b1;
          head_instruction_n = rom_q;
          head_pc_n          = inflight_pc;
        end else begin
          tail_valid_n       = 1'b1;
          tail_instruction_n = rom_q;
          tail_pc_n          = inflight_pc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc         <= RESET_BASE;
      inflight         <= 1'b0;
      inflight_pc      <= '0;
      out_valid        <= 1'b0;
      out_instruction  <= '0;
      out_pc           <= '0;
      tail_valid       <= 1'b0;
      tail_instruction <= '0;
      tail_pc          <= '0;
    end else begin
      fetch_pc         <= fetch_pc_n;
      inflight         <= issue_c;
      if (issue_c) begin
        inflight_pc <= issue_pc_c;
      end
      out_valid        <= head_valid_n;
      out_instruction  <= head_instruction_n;
      out_pc           <= head_pc_n;
      tail_valid       <= tail_valid_n;
      tail_instruction <= tail_instruction_n;
      tail_pc          <= tail_pc_n;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, randomized stream checked against
// a PC-sequence model, and a PC wrap run on a second instance with RESET_PC=0x78.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        enable;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [4:0]  rom_address;
  logic [31:0] rom_q;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;

  logic        rst_nw;
  logic [4:0]  rom_address_w;
  logic [31:0] rom_qw;
  logic        out_valid_w;
  logic [31:0] out_instruction_w;
  logic [31:0] out_pc_w;

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(.X_LENGTH(32), .ADDR_WIDTH(5), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .rom_address(rom_address), .rom_q(rom_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_instruction(out_instruction),
    .out_pc(out_pc)
  );

  fetch_sequencer #(.X_LENGTH(32), .ADDR_WIDTH(5), .RESET_PC(32'h78)) dut_wrap (
    .clk(clk), .rst_n(rst_nw), .enable(1'b1), .redirect_valid(1'b0),
    .redirect_pc(32'h0), .rom_address(rom_address_w), .rom_q(rom_qw),
    .out_valid(out_valid_w), .out_ready(1'b1), .out_instruction(out_instruction_w),
    .out_pc(out_pc_w)
  );

  function automatic logic [31:0] rom_word(input logic [4:0] a);
    return 32'h1000_0000 + 32'(a);
  endfunction

  // Synchronous ROM models: one-cycle read latency.
  always @(posedge clk) rom_q  <= rom_word(rom_address);
  always @(posedge clk) rom_qw <= rom_word(rom_address_w);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst_n;
    logic        en;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [4:0]  eaddr;
    logic        cd;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic en, input logic rv,
                              input logic [31:0] rpc, input logic rdy, input logic ev,
                              input logic [31:0] epc, input logic [4:0] eaddr, input logic cd);
    vec_t v;
    v.rst_n = r; v.en = en; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.ev = ev; v.epc = epc; v.eaddr = eaddr; v.cd = cd;
    return v;
  endfunction

  vec_t vecs[$];

  logic [31:0] exp_next;
  logic        hold;
  logic [31:0] hold_pc;
  logic [31:0] hold_ins;
  int          starve;
  logic [4:0]  wrap_addr[6];
  logic [31:0] wrap_pc[6];

  initial begin
    rst_n = 1'b0; enable = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    rst_nw = 1'b0;

    //        rst  en  rv  rpc       rdy ev  epc       addr cd
    vecs.push_back(mk(0, 1, 0, 32'h0,  1, 0, 32'h0,  5'd0,  1)); // reset values
    vecs.push_back(mk(1, 1, 0, 32'h0,  1, 0, 32'h0,  5'd0,  1)); // cycle 0
    vecs.push_back(mk(1, 1, 0, 32'h0,  1, 0, 32'h0,  5'd1,  0));
    vecs.push_back(mk(1, 1, 0, 32'h0,  1, 1, 32'h0,  5'd2,  1)); // first out in cycle 2
    vecs.push_back(mk(1, 1, 0, 32'h0,  1, 1, 32'h4,  5'd3,  1));
    vecs.push_back(mk(1, 1, 0, 32'h0,  1, 1, 32'h8,  5'd4,  1));
    vecs.push_back(mk(1, 1, 0, 32'h0,  1, 1, 32'hC,  5'd5,  1));
    for (int i = 0; i < 5; i++)                                   // stall 5 cycles
      vecs.push_back(mk(1, 1, 0, 32'h0, 0, 1, 32'h10, 5'd6, 1));
    vecs.push_back(mk(1, 1, 0, 32'h0,  1, 1, 32'h10, 5'd6,  1));
    vecs.push_back(mk(1, 1, 0, 32'h0,  1, 1, 32'h14, 5'd7,  1));
    vecs.push_back(mk(1, 1, 0, 32'h0,  1, 1, 32'h18, 5'd8,  1));
    vecs.push_back(mk(1, 1, 0, 32'h0,  1, 1, 32'h1C, 5'd9,  1));
    vecs.push_back(mk(1, 1, 1, 32'h40, 1, 1, 32'h20, 5'd16, 1)); // redirect 0x40
    vecs.push_back(mk(1, 1, 0, 32'h0,  1, 0, 32'h0,  5'd17, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,  1, 1, 32'h40, 5'd18, 1));
    vecs.push_back(mk(1, 1, 0, 32'h0,  1, 1, 32'h44, 5'd19, 1));
    vecs.push_back(mk(1, 1, 1, 32'h43, 1, 1, 32'h48, 5'd16, 1)); // unaligned redirect
    vecs.push_back(mk(1, 1, 0, 32'h0,  1, 0, 32'h0,  5'd17, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,  1, 1, 32'h40, 5'd18, 1));
    vecs.push_back(mk(1, 1, 0, 32'h0,  1, 1, 32'h44, 5'd19, 1));
    vecs.push_back(mk(1, 0, 0, 32'h0,  1, 1, 32'h48, 5'd20, 1)); // enable low 3 cycles
    vecs.push_back(mk(1, 0, 0, 32'h0,  1, 1, 32'h4C, 5'd20, 1));
    vecs.push_back(mk(1, 0, 0, 32'h0,  1, 0, 32'h0,  5'd20, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,  1, 0, 32'h0,  5'd20, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,  1, 0, 32'h0,  5'd21, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,  1, 1, 32'h50, 5'd22, 1));
    vecs.push_back(mk(1, 1, 0, 32'h0,  0, 1, 32'h54, 5'd23, 1)); // fill queue
    vecs.push_back(mk(1, 1, 0, 32'h0,  0, 1, 32'h54, 5'd23, 1));
    vecs.push_back(mk(0, 1, 1, 32'h40, 0, 1, 32'h54, 5'd0,  1)); // reset beats redirect
    vecs.push_back(mk(1, 1, 0, 32'h0,  1, 0, 32'h0,  5'd0,  1));
    vecs.push_back(mk(1, 1, 0, 32'h0,  1, 0, 32'h0,  5'd1,  0));
    vecs.push_back(mk(1, 1, 0, 32'h0,  1, 1, 32'h0,  5'd2,  1));
    vecs.push_back(mk(1, 1, 0, 32'h0,  1, 1, 32'h4,  5'd3,  1));

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n; enable = vecs[i].en; redirect_valid = vecs[i].rv;
      redirect_pc = vecs[i].rpc; out_ready = vecs[i].rdy;
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
      check($sformatf("vec%0d_addr", i), 32'(rom_address), 32'(vecs[i].eaddr));
      if (vecs[i].cd) begin
        check($sformatf("vec%0d_pc", i), out_pc, vecs[i].epc);
        check($sformatf("vec%0d_instr", i), out_instruction,
              vecs[i].ev ? rom_word(vecs[i].epc[6:2]) : 32'h0);
      end
      @(posedge clk); #1;
    end

    // Randomized phase: accepted PCs must form the architectural fetch stream.
    exp_next = 32'h0; hold = 1'b0; hold_pc = '0; hold_ins = '0; starve = 0;
    for (int i = 0; i < 3000; i++) begin
      rst_n          = (i == 0) ? 1'b0 : (($urandom % 150) != 0);
      enable         = ($urandom % 8) != 0;
      out_ready      = ($urandom % 4) != 0;
      redirect_valid = ($urandom % 20) == 0;
      redirect_pc    = $urandom;
      @(negedge clk);
      if (!rst_n) begin
        check("rand_reset_addr", 32'(rom_address), 32'h0);
        exp_next = 32'h0; hold = 1'b0; starve = 0;
      end else begin
        if (hold) begin
          check("rand_hold_valid", 32'(out_valid), 32'h1);
          check("rand_hold_pc", out_pc, hold_pc);
          check("rand_hold_instr", out_instruction, hold_ins);
        end
        if (out_valid) begin
          check("rand_instr", out_instruction, rom_word(out_pc[6:2]));
          check("rand_pc_align", 32'(out_pc[1:0]), 32'h0);
        end
        if (out_valid && out_ready) begin
          check("rand_seq_pc", out_pc, exp_next);
          exp_next = out_pc + 32'h4;
        end
        if (redirect_valid) begin
          check("rand_redir_addr", 32'(rom_address), 32'(redirect_pc[6:2]));
          exp_next = redirect_pc & ~32'h3;
        end
        hold     = out_valid && !out_ready && !redirect_valid;
        hold_pc  = out_pc;
        hold_ins = out_instruction;
        if (enable && out_ready && !redirect_valid && !out_valid) begin
          starve++;
          check("rand_starve", 32'(starve <= 2), 32'h1);
        end else begin
          starve = 0;
        end
      end
      @(posedge clk); #1;
    end

    // PC wrap across the ROM index boundary.
    wrap_addr[0] = 5'd30; wrap_addr[1] = 5'd31; wrap_addr[2] = 5'd0;
    wrap_addr[3] = 5'd1;  wrap_addr[4] = 5'd2;  wrap_addr[5] = 5'd3;
    wrap_pc[0] = 32'h0;  wrap_pc[1] = 32'h0;  wrap_pc[2] = 32'h78;
    wrap_pc[3] = 32'h7C; wrap_pc[4] = 32'h80; wrap_pc[5] = 32'h84;
    rst_nw = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("wrap%0d_addr", i), 32'(rom_address_w), 32'(wrap_addr[i]));
      check($sformatf("wrap%0d_valid", i), 32'(out_valid_w), (i >= 2) ? 32'h1 : 32'h0);
      if (i >= 2) begin
        check($sformatf("wrap%0d_pc", i), out_pc_w, wrap_pc[i]);
        check($sformatf("wrap%0d_instr", i), out_instruction_w, rom_word(wrap_pc[i][6:2]));
      end
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
